// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream byte packer: lane sizing and keep/popcount helpers.
package axis_pkg;

  localparam int unsigned MAX_BYTES     = 8;
  localparam int unsigned OUT_BYTES_DEF = 4;
  localparam int unsigned LANE_W        = $clog2(OUT_BYTES_DEF);

  // Contiguous byte-enable mask covering lanes 0..lane.
  function automatic logic [MAX_BYTES-1:0] keep_from_lane(input int unsigned lane);
    keep_from_lane = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i <= lane) keep_from_lane[i] = 1'b1;
    end
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_BYTES-1:0] v);
    popcount = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      popcount = popcount + 4'(v[i]);
    end
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// Output register for the packed stream: loads a completed word, drains on ready, holds otherwise.
module axis_out_slice
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic              last,
  output logic              valid
);

  // A load in the same cycle as a drain keeps valid high, so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= in_data;
      keep  <= in_keep;
      last  <= in_last;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into OUT_BYTES-wide little-endian words with tkeep/tlast.
// Optional statistics counters are enabled with `define AXIS_PACKER_STATS_EN.
module axis_byte_packer
  import axis_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_BYTES = 4
`ifdef AXIS_PACKER_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  output logic [IN_WIDTH*OUT_BYTES-1:0] m_tdata,
  output logic [OUT_BYTES-1:0]          m_tkeep,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
`ifdef AXIS_PACKER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          byte_count
`endif
);

  localparam int unsigned LANE_BITS = $clog2(OUT_BYTES);

  logic [OUT_BYTES-1:0][IN_WIDTH-1:0] acc;
  logic [OUT_BYTES-1:0][IN_WIDTH-1:0] word_c;
  logic [OUT_BYTES-1:0]               keep_c;
  logic [LANE_BITS-1:0]               lane;
  logic                               accept;
  logic                               complete;

  assign s_tready = !m_tvalid || m_tready;
  assign accept   = s_tvalid && s_tready;
  assign complete = accept && (s_tlast || (lane == LANE_BITS'(OUT_BYTES - 1)));
  assign keep_c   = OUT_BYTES'(keep_from_lane(32'(lane)));

  // Merge the incoming byte into the accumulated lanes; lanes above it read as zero.
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < OUT_BYTES; k++) begin
      if (k < 32'(lane))       word_c[k] = acc[k];
      else if (k == 32'(lane)) word_c[k] = s_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      if (complete) begin
        lane <= '0;
      end else begin
        acc[lane] <= s_tdata;
        lane      <= lane + LANE_BITS'(1);
      end
    end
  end

  axis_out_slice #(
    .DATA_W (IN_WIDTH * OUT_BYTES),
    .KEEP_W (OUT_BYTES)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (complete),
    .in_data (word_c),
    .in_keep (keep_c),
    .in_last (s_tlast),
    .ready   (m_tready),
    .data    (m_tdata),
    .keep    (m_tkeep),
    .last    (m_tlast),
    .valid   (m_tvalid)
  );

`ifdef AXIS_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (m_tvalid && m_tready) begin
      pkt_count  <= pkt_count + CNT_WIDTH'(m_tlast);
      byte_count <= byte_count + CNT_WIDTH'(popcount(MAX_BYTES'(m_tkeep)));
    end
  end
`endif

endmodule

// File: tb/tb_axis_byte_packer.sv
// Randomized self-checking bench for axis_byte_packer against a packet-chunking reference model.
module tb_axis_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
`ifdef AXIS_PACKER_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] byte_count;
`endif

  always #5 clk = ~clk;

  axis_byte_packer dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
`ifdef AXIS_PACKER_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .byte_count (byte_count)
`endif
  );

  typedef struct { logic [7:0] d; logic l; } in_t;
  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } out_t;

  in_t  drv_q[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   words = 0;
  int   stalls = 0;
  int   cyc = 0;
  int   last_wc = -1;
  bit   gap_chk = 1'b0;
  bit   have_prev = 1'b0;
  out_t prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a packet splits into 4-byte chunks; the final chunk carries tlast.
  task automatic add_packet(input logic [7:0] b[$]);
    int n;
    out_t w;
    for (int i = 0; i < b.size(); i += 4) begin
      n = (b.size() - i < 4) ? b.size() - i : 4;
      w.d = '0;
      for (int k = 0; k < n; k++) w.d[8*k +: 8] = b[i+k];
      w.k = 4'((1 << n) - 1);
      w.l = (i + n == b.size());
      exp_q.push_back(w);
    end
    for (int i = 0; i < b.size(); i++) drv_q.push_back('{d: b[i], l: (i == b.size() - 1)});
  endtask

  task automatic cycle(input int vpct, input int rpct);
    @(negedge clk);
    cyc++;
    check("s_tready_rule", 64'(s_tready), 64'(!m_tvalid || m_tready));
    if (have_prev) begin
      check("hold_valid", 64'(m_tvalid), 64'd1);
      check("hold_data", 64'({m_tdata, m_tkeep, m_tlast}), 64'({prev.d, prev.k, prev.l}));
    end
    have_prev = m_tvalid && !m_tready;
    prev.d = m_tdata; prev.k = m_tkeep; prev.l = m_tlast;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 64'd1, 64'd0);
      end else begin
        out_t e = exp_q.pop_front();
        check("m_tdata", 64'(m_tdata), 64'(e.d));
        check("m_tkeep", 64'(m_tkeep), 64'(e.k));
        check("m_tlast", 64'(m_tlast), 64'(e.l));
      end
      if (gap_chk && last_wc >= 0) check("word_gap", 64'(cyc - last_wc), 64'd4);
      last_wc = cyc;
      words++;
    end
    if (s_tvalid && s_tready) begin
      void'(drv_q.pop_front());
      accepted++;
    end
    if (s_tvalid && !s_tready) stalls++;
    @(posedge clk);
    #1;
    m_tready = ($urandom_range(99) < rpct);
    if (drv_q.size() > 0 && $urandom_range(99) < vpct) begin
      s_tvalid = 1'b1;
      s_tdata  = drv_q[0].d;
      s_tlast  = drv_q[0].l;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom);
    end
  endtask

  task automatic run(input int vpct, input int rpct, input int max_cyc);
    int n = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      cycle(vpct, rpct);
      n++;
    end
    check("drain_timeout", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    drv_q.delete();
    exp_q.delete();
    have_prev = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd1);
  endtask

  initial begin
    logic [7:0] b[$];
    int a0;
    int w0;
    int n;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    do_reset();

    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    add_packet(b);
    b = '{8'hAA, 8'hBB, 8'hCC};
    add_packet(b);
    b = '{8'hDD};
    add_packet(b);
    run(100, 100, 100);

    // Backpressure: one word completes, then downstream stalls.
    b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    add_packet(b);
    n = 0;
    while (!m_tvalid && n < 20) begin
      cycle(100, 0);
      n++;
    end
    check("bp_word_seen", 64'(m_tvalid), 64'd1);
    a0 = accepted;
    repeat (5) begin
      cycle(100, 0);
      check("bp_s_tready", 64'(s_tready), 64'd0);
    end
    check("bp_no_accept", 64'(accepted - a0), 64'd0);
    run(100, 100, 100);

    // Continuous stream: one word every 4 cycles, no input stall.
    b.delete();
    for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
    add_packet(b);
    stalls  = 0;
    w0      = words;
    last_wc = -1;
    gap_chk = 1'b1;
    run(100, 100, 200);
    gap_chk = 1'b0;
    check("stream_words", 64'(words - w0), 64'd16);
    check("stream_stalls", 64'(stalls), 64'd0);

    // Reset mid-word discards the partial bytes.
    drv_q.push_back('{d: 8'h55, l: 1'b0});
    drv_q.push_back('{d: 8'h66, l: 1'b0});
    n = 0;
    while (drv_q.size() > 0 && n < 20) begin
      cycle(100, 100);
      n++;
    end
    do_reset();
    b = '{8'h11, 8'h12, 8'h13, 8'h14};
    add_packet(b);
    run(100, 100, 100);

`ifdef AXIS_PACKER_STATS_EN
    do_reset();
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    add_packet(b);
    b = '{8'h41, 8'h42};
    add_packet(b);
    run(100, 100, 100);
    repeat (2) cycle(0, 100);
    check("pkt_count", 64'(pkt_count), 64'd2);
    check("byte_count", 64'(byte_count), 64'd7);
`endif

    // Random packets with random valid/ready.
    for (int p = 0; p < 25; p++) begin
      b.delete();
      n = $urandom_range(11, 1);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      add_packet(b);
    end
    run(70, 60, 3000);
    repeat (3) cycle(0, 100);
    check("final_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
